// File: rtl/seg_pkg.sv
// Shared seven-segment constants for the scan driver and the readback decoder.
// Segment bit order is bit0=a .. bit6=g; the decimal point is carried separately.
package seg_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [3:0] code_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam code_t CODE_BLANK = 4'hF;
    localparam code_t CODE_UNK   = 4'hE;

endpackage

// File: rtl/seg7_to_code.sv
// Combinational 7-segment pattern to digit code decoder.
// Any pattern outside the decimal set and blank maps to CODE_UNK.
module seg7_to_code
    import seg_pkg::*;
(
    input  logic [6:0] i_pat,
    output logic [3:0] o_code
);

    always_comb begin
        o_code = CODE_UNK;
        case (i_pat)
            SEG_0:     o_code = 4'd0;
            SEG_1:     o_code = 4'd1;
            SEG_2:     o_code = 4'd2;
            SEG_3:     o_code = 4'd3;
            SEG_4:     o_code = 4'd4;
            SEG_5:     o_code = 4'd5;
            SEG_6:     o_code = 4'd6;
            SEG_7:     o_code = 4'd7;
            SEG_8:     o_code = 4'd8;
            SEG_9:     o_code = 4'd9;
            SEG_BLANK: o_code = CODE_BLANK;
            default:   o_code = CODE_UNK;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the eight displayed characters from a multiplexed sel/seg scan bus,
// with one frame strobe per complete scan plus select-error and stall flags.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYC     = 4,
    parameter int TIMEOUT_CYC    = 100000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  sel,
    input  logic [7:0]  seg,
    output logic [31:0] digits,
    output logic [7:0]  dp,
    output logic        frame_valid,
    output logic        sel_err,
    output logic        stale
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] TO_MAX    = CW'(TIMEOUT_CYC);
    localparam logic [7:0]    STAB_MAX  = 8'(STABLE_CYC);
    localparam logic [7:0]    STAB_LAST = 8'(STABLE_CYC - 1);

    logic [7:0]    r_sel_q, r_seg_q, r_sel_prev, r_seg_prev;
    logic [7:0]    r_stab;
    logic          r_armed;
    logic [7:0]    r_seen;
    logic [31:0]   r_shadow;
    logic [7:0]    r_shadow_dp;
    logic [31:0]   r_digits;
    logic [7:0]    r_dp;
    logic          r_frame_valid;
    logic          r_sel_err;
    logic [CW-1:0] r_tcnt;

    logic [7:0]    w_sel_n, w_seg_n;
    logic          w_same, w_onehot, w_multi, w_capture;
    logic [2:0]    w_idx;
    logic [3:0]    w_code;
    logic [7:0]    w_seen_next;
    logic [31:0]   w_shadow_next;
    logic [7:0]    w_dp_next;

    assign w_sel_n = SEL_ACTIVE_LOW ? ~sel : sel;
    assign w_seg_n = SEG_ACTIVE_LOW ? ~seg : seg;

    assign w_same    = (r_sel_q == r_sel_prev) && (r_seg_q == r_seg_prev);
    assign w_multi   = (r_sel_q & (r_sel_q - 8'd1)) != '0;
    assign w_onehot  = (r_sel_q != '0) && !w_multi;
    // Capture on the cycle stab would step onto STABLE_CYC, once per dwell.
    assign w_capture = w_same && w_onehot && r_armed && (r_stab == STAB_LAST);

    always_comb begin
        w_idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (r_sel_q[i]) w_idx = 3'(i);
        end
    end

    seg7_to_code u_dec (
        .i_pat  (r_seg_q[6:0]),
        .o_code (w_code)
    );

    // Shadow set including the digit being captured, so the final digit of a
    // frame lands in the published outputs on the same edge.
    always_comb begin
        w_seen_next   = r_seen | r_sel_q;
        w_shadow_next = r_shadow;
        w_shadow_next[{w_idx, 2'b00} +: 4] = w_code;
        w_dp_next     = r_shadow_dp;
        w_dp_next[w_idx] = r_seg_q[7];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_q       <= '0;
            r_seg_q       <= '0;
            r_sel_prev    <= '0;
            r_seg_prev    <= '0;
            r_stab        <= '0;
            r_armed       <= 1'b0;
            r_seen        <= '0;
            r_shadow      <= '1;
            r_shadow_dp   <= '0;
            r_digits      <= '1;
            r_dp          <= '0;
            r_frame_valid <= 1'b0;
            r_sel_err     <= 1'b0;
            r_tcnt        <= '0;
        end else begin
            r_sel_q    <= w_sel_n;
            r_seg_q    <= w_seg_n;
            r_sel_prev <= r_sel_q;
            r_seg_prev <= r_seg_q;

            if (w_same && w_onehot) begin
                if (r_stab != STAB_MAX) r_stab <= r_stab + 8'd1;
            end else begin
                r_stab  <= '0;
                r_armed <= 1'b1;
            end

            if (w_multi) r_sel_err <= 1'b1;

            r_frame_valid <= 1'b0;
            if (w_capture) begin
                r_armed     <= 1'b0;
                r_shadow    <= w_shadow_next;
                r_shadow_dp <= w_dp_next;
                r_tcnt      <= '0;
                if (w_seen_next == 8'hFF) begin
                    r_digits      <= w_shadow_next;
                    r_dp          <= w_dp_next;
                    r_seen        <= '0;
                    r_frame_valid <= 1'b1;
                end else begin
                    r_seen <= w_seen_next;
                end
            end else if (r_tcnt != TO_MAX) begin
                r_tcnt <= r_tcnt + CW'(1);
            end
        end
    end

    assign digits      = r_digits;
    assign dp          = r_dp;
    assign frame_valid = r_frame_valid;
    assign sel_err     = r_sel_err;
    assign stale       = (r_tcnt >= TO_MAX);

endmodule
